bayer_demosaic: RTL and testbench

BAYER_DEMOSAIC -- requirements
Module: bayer_demosaic

---
 rtl/bayer_pkg.sv | 49 ++++
 rtl/bayer_win3x3.sv | 52 +++++
 rtl/bayer_demosaic.sv | 204 ++++++++++++++++++++
 tb/tb_bayer_demosaic.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bayer_pkg.sv
// Shared CFA pattern / site-phase encodings and the rounding averages used by
// the demosaic interpolator.
package bayer_pkg;

  // Internal width of the averaging helpers; callers zero-extend into it.
  localparam int AVG_W = 24;

  typedef enum logic [1:0] {
    PAT_RGGB = 2'd0,
    PAT_GRBG = 2'd1,
    PAT_GBRG = 2'd2,
    PAT_BGGR = 2'd3
  } pattern_e;

  typedef enum logic [1:0] {
    SITE_R  = 2'd0,
    SITE_GR = 2'd1,
    SITE_GB = 2'd2,
    SITE_B  = 2'd3
  } site_e;

  function automatic site_e site_phase(input logic cx0, input logic cy0, input pattern_e pat);
    logic [1:0] p;
    logic [1:0] ph;
    p  = pat;
    ph = {cy0 ^ p[1], cx0 ^ p[0]};
    case (ph)
      2'd0:    return SITE_R;
      2'd1:    return SITE_GR;
      2'd2:    return SITE_GB;
      2'd3:    return SITE_B;
      default: return SITE_R;
    endcase
  endfunction

  function automatic logic [AVG_W-1:0] avg2(input logic [AVG_W-1:0] a, input logic [AVG_W-1:0] b);
    logic [AVG_W:0] sum;
    sum = {1'b0, a} + {1'b0, b} + {{AVG_W{1'b0}}, 1'b1};
    return AVG_W'(sum >> 1);
  endfunction

  function automatic logic [AVG_W-1:0] avg4(input logic [AVG_W-1:0] a, input logic [AVG_W-1:0] b,
                                            input logic [AVG_W-1:0] c, input logic [AVG_W-1:0] d);
    logic [AVG_W+1:0] sum;
    sum = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d} + {{AVG_W{1'b0}}, 2'b10};
    return AVG_W'(sum >> 2);
  endfunction

endpackage

// File: rtl/bayer_win3x3.sv
// Two raster line buffers plus the 3x3 sliding window; win[row][col], row 0 is
// the oldest line and col 2 the newest pixel. Advances only when shift_en is high.
module bayer_win3x3 #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 1936,
  parameter int XW     = $clog2(IMG_W)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        shift_en,
  input  logic [XW-1:0]               wr_addr,
  input  logic [DATA_W-1:0]           din,
  output logic [2:0][2:0][DATA_W-1:0] win
);
  import bayer_pkg::*;

  logic [DATA_W-1:0]           lb0_r [IMG_W];
  logic [DATA_W-1:0]           lb1_r [IMG_W];
  logic [DATA_W-1:0]           up1_s;
  logic [DATA_W-1:0]           up2_s;
  logic [2:0][2:0][DATA_W-1:0] win_r;

  assign up1_s = lb0_r[wr_addr];
  assign up2_s = lb1_r[wr_addr];
  assign win   = win_r;

  // Line buffers: current pixel into line y-1 store, old y-1 into y-2 store
  always_ff @(posedge clk) begin
    if (shift_en) begin
      lb0_r[wr_addr] <= din;
      lb1_r[wr_addr] <= up1_s;
    end
  end

  // 3x3 window shift, new column enters at col 2
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_r <= {(9*DATA_W){1'b0}};
    end else if (shift_en) begin
      win_r[0][0] <= win_r[0][1];
      win_r[0][1] <= win_r[0][2];
      win_r[0][2] <= up2_s;
      win_r[1][0] <= win_r[1][1];
      win_r[1][1] <= win_r[1][2];
      win_r[1][2] <= up1_s;
      win_r[2][0] <= win_r[2][1];
      win_r[2][1] <= win_r[2][2];
      win_r[2][2] <= din;
    end
  end

endmodule

// File: rtl/bayer_demosaic.sv
// Bilinear Bayer demosaic to {R,G,B}, 2-cycle latency from the completing pixel.
// Optional crop window enabled by defining BAYER_DEMOSAIC_CROP_EN.
module bayer_demosaic #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 1936,
  parameter int IMG_H  = 1088,
  parameter int WIN_X  = 500,
  parameter int WIN_Y  = 500,
  parameter int WIN_W  = 640,
  parameter int WIN_H  = 480
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            pattern,
  input  logic                  in_valid,
  input  logic                  in_sof,
  input  logic [DATA_W-1:0]     in_raw,
  output logic                  out_valid,
  output logic                  out_sof,
  output logic                  out_eol,
  output logic [3*DATA_W-1:0]   out_rgb
);
  import bayer_pkg::*;

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);

`ifdef BAYER_DEMOSAIC_CROP_EN
  localparam int CX_LO = (WIN_X > 1) ? WIN_X : 1;
  localparam int CY_LO = (WIN_Y > 1) ? WIN_Y : 1;
  localparam int CX_HI = (WIN_X + WIN_W - 1 < IMG_W - 2) ? WIN_X + WIN_W - 1 : IMG_W - 2;
  localparam int CY_HI = (WIN_Y + WIN_H - 1 < IMG_H - 2) ? WIN_Y + WIN_H - 1 : IMG_H - 2;
`else
  // Window parameters have no effect without crop; the zero term keeps them referenced.
  localparam int CX_LO = 1 + 0 * (WIN_X + WIN_Y + WIN_W + WIN_H);
  localparam int CY_LO = 1;
  localparam int CX_HI = IMG_W - 2;
  localparam int CY_HI = IMG_H - 2;
`endif

  localparam logic [XW-1:0] X_LAST  = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(IMG_H - 1);
  localparam logic [XW-1:0] CX_LO_L = XW'(CX_LO);
  localparam logic [XW-1:0] CX_HI_L = XW'(CX_HI);
  localparam logic [YW-1:0] CY_LO_L = YW'(CY_LO);
  localparam logic [YW-1:0] CY_HI_L = YW'(CY_HI);

  logic [XW-1:0]               x_r, cur_x_s, cen_x_s;
  logic [YW-1:0]               y_r, cur_y_s, cen_y_s;
  logic [1:0]                  pat_r, pat_s;
  logic                        active_r, accept_s, kill_s, elig_s;
  site_e                       site_s, s1_site_r;
  logic [2:0][2:0][DATA_W-1:0] win_s;
  logic                        s1_valid_r, s1_sof_r, s1_eol_r;
  logic                        s2_valid_r, s2_sof_r, s2_eol_r;
  logic [3*DATA_W-1:0]         s2_rgb_r;
  logic [AVG_W-1:0]            cross4_w_s, diag4_w_s, horz2_w_s, vert2_w_s;
  logic [DATA_W-1:0]           cross4_s, diag4_s, horz2_s, vert2_s;
  logic [DATA_W-1:0]           r_s, g_s, b_s;

  function automatic logic [DATA_W-1:0] fit(input logic [AVG_W-1:0] v);
    if (|v[AVG_W-1:DATA_W]) begin
      fit = {DATA_W{1'b1}};
    end else begin
      fit = v[DATA_W-1:0];
    end
  endfunction

  // Position of the pixel on in_raw and eligibility of the centre it completes
  always_comb begin
    accept_s = in_valid & (in_sof | active_r);
    kill_s   = in_valid & in_sof;
    if (in_sof) begin
      cur_x_s = {XW{1'b0}};
      cur_y_s = {YW{1'b0}};
      pat_s   = pattern;
    end else begin
      cur_x_s = x_r;
      cur_y_s = y_r;
      pat_s   = pat_r;
    end
    cen_x_s = cur_x_s - XW'(1);
    cen_y_s = cur_y_s - YW'(1);
    elig_s  = (cen_x_s >= CX_LO_L) && (cen_x_s <= CX_HI_L) &&
              (cen_y_s >= CY_LO_L) && (cen_y_s <= CY_HI_L);
    site_s  = site_phase(cen_x_s[0], cen_y_s[0], pattern_e'(pat_s));
  end

  // Raster counters, frame-active flag and per-frame pattern
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_r      <= {XW{1'b0}};
      y_r      <= {YW{1'b0}};
      active_r <= 1'b0;
      pat_r    <= 2'b00;
    end else if (accept_s) begin
      pat_r <= pat_s;
      if (cur_x_s == X_LAST) begin
        x_r <= {XW{1'b0}};
        if (cur_y_s == Y_LAST) begin
          y_r      <= {YW{1'b0}};
          active_r <= 1'b0;
        end else begin
          y_r      <= cur_y_s + YW'(1);
          active_r <= 1'b1;
        end
      end else begin
        x_r      <= cur_x_s + XW'(1);
        y_r      <= cur_y_s;
        active_r <= 1'b1;
      end
    end
  end

  bayer_win3x3 #(
    .DATA_W (DATA_W),
    .IMG_W  (IMG_W),
    .XW     (XW)
  ) u_win (
    .clk      (clk),
    .rst      (rst),
    .shift_en (accept_s),
    .wr_addr  (cur_x_s),
    .din      (in_raw),
    .win      (win_s)
  );

  // Stage 1: sideband for the window just formed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_sof_r   <= 1'b0;
      s1_eol_r   <= 1'b0;
      s1_site_r  <= SITE_R;
    end else begin
      s1_valid_r <= accept_s & elig_s;
      if (accept_s) begin
        s1_sof_r  <= (cen_x_s == CX_LO_L) && (cen_y_s == CY_LO_L);
        s1_eol_r  <= (cen_x_s == CX_HI_L);
        s1_site_r <= site_s;
      end
    end
  end

  assign cross4_w_s = avg4(AVG_W'(win_s[0][1]), AVG_W'(win_s[2][1]), AVG_W'(win_s[1][0]), AVG_W'(win_s[1][2]));
  assign diag4_w_s  = avg4(AVG_W'(win_s[0][0]), AVG_W'(win_s[0][2]), AVG_W'(win_s[2][0]), AVG_W'(win_s[2][2]));
  assign horz2_w_s  = avg2(AVG_W'(win_s[1][0]), AVG_W'(win_s[1][2]));
  assign vert2_w_s  = avg2(AVG_W'(win_s[0][1]), AVG_W'(win_s[2][1]));
  assign cross4_s   = fit(cross4_w_s);
  assign diag4_s    = fit(diag4_w_s);
  assign horz2_s    = fit(horz2_w_s);
  assign vert2_s    = fit(vert2_w_s);

  // Colour selection by site phase
  always_comb begin
    r_s = win_s[1][1];
    g_s = win_s[1][1];
    b_s = win_s[1][1];
    case (s1_site_r)
      SITE_R:  begin r_s = win_s[1][1]; g_s = cross4_s;    b_s = diag4_s;     end
      SITE_B:  begin r_s = diag4_s;     g_s = cross4_s;    b_s = win_s[1][1]; end
      SITE_GR: begin r_s = horz2_s;     g_s = win_s[1][1]; b_s = vert2_s;     end
      SITE_GB: begin r_s = vert2_s;     g_s = win_s[1][1]; b_s = horz2_s;     end
      default: begin r_s = win_s[1][1]; g_s = win_s[1][1]; b_s = win_s[1][1]; end
    endcase
  end

  // Stage 2: interpolated pixel; a new frame start discards anything in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_r <= 1'b0;
      s2_sof_r   <= 1'b0;
      s2_eol_r   <= 1'b0;
      s2_rgb_r   <= {(3*DATA_W){1'b0}};
    end else begin
      s2_valid_r <= s1_valid_r & ~kill_s;
      if (s1_valid_r) begin
        s2_sof_r <= s1_sof_r;
        s2_eol_r <= s1_eol_r;
        s2_rgb_r <= {r_s, g_s, b_s};
      end
    end
  end

  // Output register; out_rgb holds between valid pixels
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
      out_rgb   <= {(3*DATA_W){1'b0}};
    end else if (s2_valid_r && !kill_s) begin
      out_valid <= 1'b1;
      out_sof   <= s2_sof_r;
      out_eol   <= s2_eol_r;
      out_rgb   <= s2_rgb_r;
    end else begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bayer_demosaic.sv
// Self-checking bench for bayer_demosaic on a 16x12 image; crop expectations
// follow BAYER_DEMOSAIC_CROP_EN when it is defined.
module tb_bayer_demosaic;

  localparam int DW = 8;
  localparam int IW = 16;
  localparam int IH = 12;
  localparam int WX = 4;
  localparam int WY = 3;
  localparam int WW = 5;
  localparam int WH = 4;

`ifdef BAYER_DEMOSAIC_CROP_EN
  localparam int XLO = (WX > 1) ? WX : 1;
  localparam int YLO = (WY > 1) ? WY : 1;
  localparam int XHI = (WX + WW - 1 < IW - 2) ? WX + WW - 1 : IW - 2;
  localparam int YHI = (WY + WH - 1 < IH - 2) ? WY + WH - 1 : IH - 2;
`else
  localparam int XLO = 1;
  localparam int YLO = 1;
  localparam int XHI = IW - 2;
  localparam int YHI = IH - 2;
`endif
  localparam int N_OUT = (XHI - XLO + 1) * (YHI - YLO + 1);
  localparam int N_EOL = YHI - YLO + 1;

  typedef struct {
    int          due;
    logic [23:0] rgb;
    bit          sof;
    bit          eol;
  } exp_t;

  logic          clk;
  logic          rst;
  logic [1:0]    pattern;
  logic          in_valid;
  logic          in_sof;
  logic [DW-1:0] in_raw;
  logic          out_valid;
  logic          out_sof;
  logic          out_eol;
  logic [3*DW-1:0] out_rgb;

  int          frame [IH][IW];
  int          mimg  [IH][IW];
  int          mx, my, mpat, cyc;
  bit          mact;
  exp_t        q [$];
  logic [23:0] last_rgb;
  logic [23:0] const_rgb;
  bit          const_en;
  int          n_valid, n_sof, n_eol;
  int          vectors, miscompares;

  bayer_demosaic #(
    .DATA_W (DW), .IMG_W (IW), .IMG_H (IH),
    .WIN_X (WX), .WIN_Y (WY), .WIN_W (WW), .WIN_H (WH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pattern   (pattern),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_raw    (in_raw),
    .out_valid (out_valid),
    .out_sof   (out_sof),
    .out_eol   (out_eol),
    .out_rgb   (out_rgb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // CFA colour of a pixel: 0=R, 1=G, 2=B
  function automatic int colour_at(input int x, input int y, input int pat);
    int ph;
    ph = (((y & 1) ^ ((pat >> 1) & 1)) * 2) + ((x & 1) ^ (pat & 1));
    if (ph == 0) return 0;
    else if (ph == 3) return 2;
    else return 1;
  endfunction

  // Own colour from the centre, others as rounded mean of same-colour neighbours
  function automatic logic [23:0] ref_pixel(input int cx, input int cy);
    int val [3];
    int sum, n;
    for (int ch = 0; ch < 3; ch++) begin
      if (colour_at(cx, cy, mpat) == ch) begin
        val[ch] = mimg[cy][cx];
      end else begin
        sum = 0;
        n = 0;
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++)
            if (colour_at(cx + dx, cy + dy, mpat) == ch) begin
              sum += mimg[cy + dy][cx + dx];
              n++;
            end
        val[ch] = (sum + n / 2) / n;
      end
    end
    return {val[0][7:0], val[1][7:0], val[2][7:0]};
  endfunction

  task automatic check();
    exp_t e;
    bit   ev;
    ev = 1'b0;
    if (q.size() > 0 && q[0].due == cyc) begin
      e  = q.pop_front();
      ev = 1'b1;
    end
    vectors++;
    assert (out_valid === ev) else begin
      miscompares++;
      $error("FAIL out_valid cyc=%0d observed=%b expected=%b", cyc, out_valid, ev);
    end
    if (out_valid === 1'b1) begin
      n_valid++;
      if (out_sof === 1'b1) n_sof++;
      if (out_eol === 1'b1) n_eol++;
    end
    if (ev) begin
      vectors++;
      assert (out_rgb === e.rgb) else begin
        miscompares++;
        $error("FAIL out_rgb cyc=%0d observed=%h expected=%h", cyc, out_rgb, e.rgb);
      end
      vectors++;
      assert (out_sof === e.sof) else begin
        miscompares++;
        $error("FAIL out_sof cyc=%0d observed=%b expected=%b", cyc, out_sof, e.sof);
      end
      vectors++;
      assert (out_eol === e.eol) else begin
        miscompares++;
        $error("FAIL out_eol cyc=%0d observed=%b expected=%b", cyc, out_eol, e.eol);
      end
      if (const_en) begin
        vectors++;
        assert (out_rgb === const_rgb) else begin
          miscompares++;
          $error("FAIL flat_rgb cyc=%0d observed=%h expected=%h", cyc, out_rgb, const_rgb);
        end
      end
      last_rgb = e.rgb;
    end else begin
      vectors++;
      assert (out_rgb === last_rgb) else begin
        miscompares++;
        $error("FAIL rgb_hold cyc=%0d observed=%h expected=%h", cyc, out_rgb, last_rgb);
      end
      vectors++;
      assert (out_sof === 1'b0 && out_eol === 1'b0) else begin
        miscompares++;
        $error("FAIL idle_flags cyc=%0d observed=%b%b expected=00", cyc, out_sof, out_eol);
      end
    end
  endtask

  // One clock: drive inputs, advance the model, then check after the edge
  task automatic step(input bit v, input bit s, input int d);
    in_valid = v;
    in_sof   = s;
    in_raw   = d[7:0];
    @(posedge clk);
    cyc++;
    if (v && (s || mact)) begin
      if (s) begin
        mact = 1'b1;
        mx   = 0;
        my   = 0;
        mpat = int'(pattern);
        while (q.size() > 0 && q[$].due >= cyc) void'(q.pop_back());
      end
      mimg[my][mx] = d;
      if (mx - 1 >= XLO && mx - 1 <= XHI && my - 1 >= YLO && my - 1 <= YHI)
        q.push_back('{cyc + 2, ref_pixel(mx - 1, my - 1),
                      (mx - 1 == XLO) && (my - 1 == YLO), (mx - 1 == XHI)});
      if (mx == IW - 1) begin
        mx = 0;
        if (my == IH - 1) begin
          my   = 0;
          mact = 1'b0;
        end else begin
          my++;
        end
      end else begin
        mx++;
      end
    end
    #1;
    check();
  endtask

  task automatic fill(input int kind, input int pat);
    for (int y = 0; y < IH; y++)
      for (int x = 0; x < IW; x++)
        case (kind)
          0: frame[y][x] = 100;
          1: frame[y][x] = (colour_at(x, y, pat) == 0) ? 200 : (colour_at(x, y, pat) == 1) ? 100 : 50;
          2: frame[y][x] = int'($urandom_range(255, 0));
          default: frame[y][x] = int'($urandom_range(3, 0));
        endcase
  endtask

  // Send the first n pixels of frame[] starting with in_sof; gap is idle-cycle percentage
  task automatic send(input int pat, input int gap, input int n);
    pattern = pat[1:0];
    for (int i = 0; i < n; i++) begin
      while (gap > 0 && int'($urandom_range(99, 0)) < gap) step(1'b0, 1'b0, int'($urandom_range(255, 0)));
      step(1'b1, i == 0, frame[i / IW][i % IW]);
      if (i == 0) pattern = 2'($urandom_range(3, 0));
    end
  endtask

  task automatic clear_counts();
    n_valid = 0;
    n_sof   = 0;
    n_eol   = 0;
  endtask

  task automatic frame_done(input int pat, input int gap);
    clear_counts();
    send(pat, gap, IW * IH);
    repeat (4) step(1'b0, 1'b0, 0);
    vectors++;
    assert (n_valid == N_OUT) else begin
      miscompares++;
      $error("FAIL frame_count observed=%0d expected=%0d", n_valid, N_OUT);
    end
    vectors++;
    assert (n_sof == 1) else begin
      miscompares++;
      $error("FAIL frame_sof observed=%0d expected=1", n_sof);
    end
    vectors++;
    assert (n_eol == N_EOL) else begin
      miscompares++;
      $error("FAIL frame_eol observed=%0d expected=%0d", n_eol, N_EOL);
    end
  endtask

  task automatic check_cleared(input string tag);
    vectors++;
    assert (out_valid === 1'b0 && out_sof === 1'b0 && out_eol === 1'b0 && out_rgb === 24'h000000) else begin
      miscompares++;
      $error("FAIL %s observed=%b%b%b/%h expected=000/000000", tag, out_valid, out_sof, out_eol, out_rgb);
    end
  endtask

  task automatic pulse_reset();
    in_valid = 1'b0;
    in_sof   = 1'b0;
    #1 rst = 1'b1;
    #1;
    check_cleared("reset_clear");
    q.delete();
    mact     = 1'b0;
    last_rgb = 24'h000000;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; pattern = 2'b00; in_valid = 1'b0; in_sof = 1'b0; in_raw = 8'h00;
    mx = 0; my = 0; mpat = 0; mact = 1'b0; cyc = 0;
    last_rgb = 24'h000000; const_rgb = 24'h000000; const_en = 1'b0;
    vectors = 0; miscompares = 0;
    clear_counts();
    #1 rst = 1'b1;
    #2;
    check_cleared("reset_state");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Pixels before the first frame start are ignored
    repeat (20) step(1'b1, 1'b0, int'($urandom_range(255, 0)));

    // Flat grey frame
    fill(0, 0);
    const_en = 1'b1; const_rgb = {8'd100, 8'd100, 8'd100};
    frame_done(0, 0);

    // Pure-colour scene under every CFA phase
    const_rgb = {8'd200, 8'd100, 8'd50};
    for (int p = 0; p < 4; p++) begin
      fill(1, p);
      frame_done(p, 0);
    end
    const_en = 1'b0;

    // Random content, gap-free then with 50% idle cycles
    fill(2, 0);
    frame_done(1, 0);
    frame_done(1, 50);
    fill(3, 0);
    frame_done(3, 30);
    frame_done(0, 0);

    // Frame restart injected at pixel (3,2)
    fill(2, 0);
    send(2, 0, 2 * IW + 3);
    fill(2, 0);
    frame_done(2, 0);

    // Reset mid-frame, stray pixels, then a clean frame
    send(0, 20, 5 * IW + 7);
    pulse_reset();
    clear_counts();
    repeat (30) step(1'b1, 1'b0, int'($urandom_range(255, 0)));
    vectors++;
    assert (n_valid == 0) else begin
      miscompares++;
      $error("FAIL post_reset_quiet observed=%0d expected=0", n_valid);
    end
    fill(2, 0);
    frame_done(3, 10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
